msrv32_imm_sequencer: RTL and testbench

Two-stage, valid/ready-handshaked immediate decode pipeline sitting between the fetch/instruction register and the execute-stage operand muxes. It classifies each accepted 32-bit instruction by opcode into a 3-bit immediate type, then produces the sign/zero-extended 32-bit immediate one stage later. It also flags unsupported opcodes and keeps a saturating illegal-instruction count. It applies back-pressure upstream and honours a pipeline flush.

---
 rtl/msrv32_imm_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_msrv32_imm_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_imm_sequencer.sv
// ============================================================================
// msrv32_imm_sequencer
// ----------------------------------------------------------------------------
// Two-stage valid/ready immediate decode pipeline between the instruction
// register and the execute-stage operand muxes.
//
//   Stage 1 : classifies the accepted instruction by opcode into a 3-bit
//             immediate type, flags unsupported opcodes and keeps the
//             instruction bits [31:7] needed to build the immediate.
//   Stage 2 : builds the sign/zero-extended 32-bit immediate and presents
//             it downstream together with the type and the illegal flag.
//
// A saturating counter records how many illegal instructions were handed
// downstream. Flush drops everything in flight but never clears the counter.
//
// Optional feature macro: MSRV32_IMM_CSR_EN
//   defined   : SYSTEM opcode with funct3[2]=1 decodes to type 110 (CSR zimm)
//   undefined : every SYSTEM opcode decodes to type 000
//
// Parameters
//   CNT_W              width of the saturating illegal-instruction counter
//
// Ports
//   clk_in             clock, rising edge
//   rst_in             asynchronous reset, active low
//   flush_in           synchronous flush of all in-flight entries
//   instr_valid_in     upstream instruction valid
//   instr_in[31:0]     instruction word
//   instr_ready_out    block can accept an instruction this cycle
//   imm_valid_out      stage-2 result valid
//   imm_ready_in       downstream accepts the result
//   imm_out[31:0]      generated immediate
//   imm_type_out[2:0]  decoded immediate type
//   illegal_out        unsupported opcode; imm_out is zero
//   illegal_count_out  saturating count of illegal instructions delivered
// ============================================================================
module msrv32_imm_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             instr_valid_in,
    input  logic [31:0]      instr_in,
    output logic             instr_ready_out,
    output logic             imm_valid_out,
    input  logic             imm_ready_in,
    output logic [31:0]      imm_out,
    output logic [2:0]       imm_type_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] illegal_count_out
);

    // Immediate type encoding presented on imm_type_out.
    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_JALR = 3'b001,
        IMM_S    = 3'b010,
        IMM_B    = 3'b011,
        IMM_U    = 3'b100,
        IMM_J    = 3'b101,
        IMM_Z    = 3'b110,
        IMM_RSV  = 3'b111
    } imm_type_e;

    // Opcodes recognised by the decoder.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage-1 state. Only bits [31:7] are kept: the opcode has already been
    // folded into the type, and bits [6:0] never feed any immediate.
    logic        s1_valid;
    logic [31:7] s1_instr;
    imm_type_e   s1_type;
    logic        s1_illegal;
    logic        s1_zero;

    // Decoder outputs for the instruction currently on instr_in.
    imm_type_e   dec_type;
    logic        dec_illegal;
    logic        dec_zero;

    // Immediate built from stage-1 contents, registered into stage 2.
    logic [31:0] imm_next;

    // Handshake helpers.
    logic        s2_adv;
    logic        accept;
    logic        out_fire;

    // Stage 1 may hand over whenever stage 2 is empty or is being drained
    // this cycle. The ready path back to the fetch stage is combinational
    // from imm_ready_in so a full pipeline stalls in the same cycle.
    assign s2_adv          = s1_valid && (!imm_valid_out || imm_ready_in);
    assign instr_ready_out = (!s1_valid || s2_adv) && !flush_in;
    assign accept          = instr_valid_in && instr_ready_out;
    assign out_fire        = imm_valid_out && imm_ready_in;

    // Opcode classification. Register-register ops and fences are legal but
    // carry no immediate, so they share the illegal path's forced-zero flag
    // without raising illegal. Any opcode not listed is illegal.
    always_comb begin
        dec_type    = IMM_I;
        dec_illegal = 1'b0;
        dec_zero    = 1'b0;
        case (instr_in[6:0])
            OP_LOAD, OP_IMM: dec_type = IMM_I;
            OP_JALR:         dec_type = IMM_JALR;
            OP_STORE:        dec_type = IMM_S;
            OP_BRANCH:       dec_type = IMM_B;
            OP_LUI, OP_AUIPC: dec_type = IMM_U;
            OP_JAL:          dec_type = IMM_J;
            OP_SYSTEM: begin
`ifdef MSRV32_IMM_CSR_EN
                // funct3[2] selects the CSR immediate forms (csrrwi etc.).
                if (instr_in[14]) begin
                    dec_type = IMM_Z;
                end else begin
                    dec_type = IMM_I;
                end
`else
                dec_type = IMM_I;
`endif
            end
            OP_REG, OP_FENCE: begin
                dec_type = IMM_I;
                dec_zero = 1'b1;
            end
            default: begin
                dec_type    = IMM_I;
                dec_illegal = 1'b1;
                dec_zero    = 1'b1;
            end
        endcase
    end

    // Immediate construction from the stage-1 instruction bits. The reserved
    // type falls back to the I-type layout so the output is always defined.
    always_comb begin
        imm_next = {{20{s1_instr[31]}}, s1_instr[31:20]};
        case (s1_type)
            IMM_I, IMM_JALR, IMM_RSV: begin
                imm_next = {{20{s1_instr[31]}}, s1_instr[31:20]};
            end
            IMM_S: begin
                imm_next = {{20{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
            end
            IMM_B: begin
                imm_next = {{19{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                            s1_instr[30:25], s1_instr[11:8], 1'b0};
            end
            IMM_U: begin
                imm_next = {s1_instr[31:12], 12'h000};
            end
            IMM_J: begin
                imm_next = {{11{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                            s1_instr[20], s1_instr[30:21], 1'b0};
            end
            IMM_Z: begin
                imm_next = {27'd0, s1_instr[19:15]};
            end
            default: begin
                imm_next = {{20{s1_instr[31]}}, s1_instr[31:20]};
            end
        endcase
        if (s1_zero) begin
            imm_next = 32'd0;
        end
    end

    // Stage 1 register. Flush wins over a same-cycle accept; otherwise a new
    // accept refills the stage, and a hand-over with no refill empties it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid   <= 1'b0;
            s1_instr   <= '0;
            s1_type    <= IMM_I;
            s1_illegal <= 1'b0;
            s1_zero    <= 1'b0;
        end else if (flush_in) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_instr   <= instr_in[31:7];
            s1_type    <= dec_type;
            s1_illegal <= dec_illegal;
            s1_zero    <= dec_zero;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 register. Data only changes on a hand-over from stage 1, so the
    // outputs stay frozen while downstream stalls. Flush invalidates the
    // stage; a result already handed over in that cycle has left regardless.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            imm_valid_out <= 1'b0;
            imm_out       <= 32'd0;
            imm_type_out  <= 3'b000;
            illegal_out   <= 1'b0;
        end else if (flush_in) begin
            imm_valid_out <= 1'b0;
        end else if (s2_adv) begin
            imm_valid_out <= 1'b1;
            imm_out       <= imm_next;
            imm_type_out  <= s1_type;
            illegal_out   <= s1_illegal;
        end else if (out_fire) begin
            imm_valid_out <= 1'b0;
        end
    end

    // Illegal-instruction counter. Counts completed handshakes only, so an
    // illegal result leaving during a flush still counts; it sticks at its
    // maximum and only reset clears it.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            illegal_count_out <= '0;
        end else if (out_fire && illegal_out && (illegal_count_out != CNT_MAX)) begin
            illegal_count_out <= illegal_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_msrv32_imm_sequencer.sv
// ============================================================================
// tb_msrv32_imm_sequencer
// ----------------------------------------------------------------------------
// Directed self-checking bench for msrv32_imm_sequencer. Each offered
// instruction carries a hand-computed expected immediate, type and illegal
// flag; accepted instructions go into an expectation queue that a negedge
// monitor drains as results are handed downstream.
// ============================================================================
module tb_msrv32_imm_sequencer;

    logic        clk_in;
    logic        rst_in;
    logic        flush_in;
    logic        instr_valid_in;
    logic [31:0] instr_in;
    logic        instr_ready_out;
    logic        imm_valid_out;
    logic        imm_ready_in;
    logic [31:0] imm_out;
    logic [2:0]  imm_type_out;
    logic        illegal_out;
    logic [7:0]  illegal_count_out;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } exp_t;

    exp_t expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    logic        heldValid = 1'b0;
    logic [31:0] heldImm;
    logic [2:0]  heldType;
    logic        heldIll;

    msrv32_imm_sequencer #(.CNT_W(8)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .flush_in          (flush_in),
        .instr_valid_in    (instr_valid_in),
        .instr_in          (instr_in),
        .instr_ready_out   (instr_ready_out),
        .imm_valid_out     (imm_valid_out),
        .imm_ready_in      (imm_ready_in),
        .imm_out           (imm_out),
        .imm_type_out      (imm_type_out),
        .illegal_out       (illegal_out),
        .illegal_count_out (illegal_count_out)
    );

    // 10 ns clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Offers one instruction until it is accepted, recording the expected
    // result at the accepting edge. Returns 1 ns after that edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] eImm,
                                 input logic [2:0] eType, input logic eIll);
        exp_t e;
        bit   done;
        done           = 1'b0;
        instr_valid_in = 1'b1;
        instr_in       = instr;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk_in);
            if (instr_ready_out && !flush_in) begin
                e.imm = eImm;
                e.typ = eType;
                e.ill = eIll;
                expQ.push_back(e);
                done = 1'b1;
            end
            @(posedge clk_in);
            #1;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Stops offering and waits until every expected result has been delivered.
    task automatic drainPipe();
        bit done;
        done           = 1'b0;
        instr_valid_in = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk_in);
            if (expQ.size() == 0 && !imm_valid_out) done = 1'b1;
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    // Output monitor: checks hold-stability during stalls and compares each
    // handshaked result against the head of the expectation queue.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in) begin
            heldValid = 1'b0;
        end else begin
            if (heldValid && imm_valid_out) begin
                checkOutput("hold_imm", imm_out, heldImm);
                checkOutput("hold_type", {29'd0, imm_type_out}, {29'd0, heldType});
                checkOutput("hold_ill", {31'd0, illegal_out}, {31'd0, heldIll});
            end
            heldValid = imm_valid_out && !imm_ready_in;
            heldImm   = imm_out;
            heldType  = imm_type_out;
            heldIll   = illegal_out;
            if (imm_valid_out && imm_ready_in) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out", imm_out, 32'hDEAD_BEEF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("imm", imm_out, e.imm);
                    checkOutput("type", {29'd0, imm_type_out}, {29'd0, e.typ});
                    checkOutput("illegal", {31'd0, illegal_out}, {31'd0, e.ill});
                end
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        time t0;
        logic [31:0] csrImm;
        logic [2:0]  csrType;

        rst_in         = 1'b0;
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        instr_in       = 32'd0;
        imm_ready_in   = 1'b1;

        // Reset values.
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("rst_valid", {31'd0, imm_valid_out}, 32'd0);
        checkOutput("rst_imm", imm_out, 32'd0);
        checkOutput("rst_type", {29'd0, imm_type_out}, 32'd0);
        checkOutput("rst_ill", {31'd0, illegal_out}, 32'd0);
        checkOutput("rst_cnt", {24'd0, illegal_count_out}, 32'd0);
        checkOutput("rst_ready", {31'd0, instr_ready_out}, 32'd1);
        @(posedge clk_in);
        #1;

        // Latency: result becomes visible after the edge following acceptance.
        applyStimulus(32'hFFF00093, 32'hFFFF_FFFF, 3'b000, 1'b0);
        instr_valid_in = 1'b0;
        @(negedge clk_in);
        checkOutput("lat_n1_valid", {31'd0, imm_valid_out}, 32'd0);
        @(negedge clk_in);
        checkOutput("lat_n2_valid", {31'd0, imm_valid_out}, 32'd1);
        drainPipe();
        @(posedge clk_in);
        #1;

        // Back-to-back stream, one accept per cycle.
        // Branch 0xFE000EE3: imm[12]=1, imm[11]=i[7]=1, imm[10:5]=111111,
        // imm[4:1]=1110 -> -4.
        t0 = $time;
        applyStimulus(32'hFFF00093, 32'hFFFF_FFFF, 3'b000, 1'b0);
        applyStimulus(32'h00112423, 32'h0000_0008, 3'b010, 1'b0);
        applyStimulus(32'hFE000EE3, 32'hFFFF_FFFC, 3'b011, 1'b0);
        applyStimulus(32'h123450B7, 32'h1234_5000, 3'b100, 1'b0);
        applyStimulus(32'h0080006F, 32'h0000_0008, 3'b101, 1'b0);
        checkOutput("throughput_cycles", 32'(($time - t0) / 10), 32'd5);
        applyStimulus(32'h00C08067, 32'h0000_000C, 3'b001, 1'b0);
        applyStimulus(32'h00208033, 32'h0000_0000, 3'b000, 1'b0);
        applyStimulus(32'h0FF0000F, 32'h0000_0000, 3'b000, 1'b0);
        applyStimulus(32'h00001017, 32'h0000_1000, 3'b100, 1'b0);
        applyStimulus(32'h80002083, 32'hFFFF_F800, 3'b000, 1'b0);
        drainPipe();

        // Stall: two accepted, third held off, outputs frozen.
        @(posedge clk_in);
        #1;
        imm_ready_in = 1'b0;
        applyStimulus(32'h00112423, 32'h0000_0008, 3'b010, 1'b0);
        applyStimulus(32'h123450B7, 32'h1234_5000, 3'b100, 1'b0);
        instr_valid_in = 1'b1;
        instr_in       = 32'hFFF00093;
        repeat (3) begin
            @(negedge clk_in);
            checkOutput("stall_ready", {31'd0, instr_ready_out}, 32'd0);
            checkOutput("stall_imm", imm_out, 32'h0000_0008);
        end
        @(posedge clk_in);
        #1;
        imm_ready_in = 1'b1;
        applyStimulus(32'hFFF00093, 32'hFFFF_FFFF, 3'b000, 1'b0);
        drainPipe();

        // CSR immediate form.
`ifdef MSRV32_IMM_CSR_EN
        csrImm  = 32'h0000_0001;
        csrType = 3'b110;
`else
        csrImm  = 32'h0000_0340;
        csrType = 3'b000;
`endif
        @(posedge clk_in);
        #1;
        applyStimulus(32'h3400D073, csrImm, csrType, 1'b0);
        drainPipe();

        // Flush with both stages full: the illegal head still completes its
        // handshake and is counted; the stage-1 entry and the offered one vanish.
        @(posedge clk_in);
        #1;
        imm_ready_in = 1'b0;
        applyStimulus(32'h0000007F, 32'h0000_0000, 3'b000, 1'b1);
        applyStimulus(32'h123450B7, 32'h1234_5000, 3'b100, 1'b0);
        imm_ready_in   = 1'b1;
        flush_in       = 1'b1;
        instr_valid_in = 1'b1;
        instr_in       = 32'h0080006F;
        @(negedge clk_in);
        checkOutput("flush_ready", {31'd0, instr_ready_out}, 32'd0);
        @(posedge clk_in);
        #1;
        flush_in       = 1'b0;
        instr_valid_in = 1'b0;
        while (expQ.size() > 0) void'(expQ.pop_back());
        @(negedge clk_in);
        checkOutput("flush_valid", {31'd0, imm_valid_out}, 32'd0);
        checkOutput("flush_cnt", {24'd0, illegal_count_out}, 32'd1);
        checkOutput("flush_ready_after", {31'd0, instr_ready_out}, 32'd1);
        @(posedge clk_in);
        #1;
        applyStimulus(32'h00C08067, 32'h0000_000C, 3'b001, 1'b0);
        drainPipe();

        // Asynchronous reset mid-operation.
        @(posedge clk_in);
        #1;
        applyStimulus(32'h00112423, 32'h0000_0008, 3'b010, 1'b0);
        applyStimulus(32'h0000007F, 32'h0000_0000, 3'b000, 1'b1);
        instr_valid_in = 1'b0;
        #2;
        rst_in = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, imm_valid_out}, 32'd0);
        checkOutput("mid_rst_cnt", {24'd0, illegal_count_out}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, instr_ready_out}, 32'd1);
        while (expQ.size() > 0) void'(expQ.pop_back());
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checkOutput("post_rst_valid", {31'd0, imm_valid_out}, 32'd0);
        @(posedge clk_in);
        #1;

        // Illegal stream: counter counts then saturates at 255.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0000007F, 32'h0000_0000, 3'b000, 1'b1);
        end
        drainPipe();
        checkOutput("ill_cnt_3", {24'd0, illegal_count_out}, 32'd3);
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 297; i++) begin
            applyStimulus(32'h0000007F, 32'h0000_0000, 3'b000, 1'b1);
        end
        drainPipe();
        checkOutput("ill_cnt_sat", {24'd0, illegal_count_out}, 32'd255);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
